// File: rtl/alu_seq_pipe_if.sv
// Issue/writeback handshake bundle for alu_seq_pipe: operands in, result and flags out.
interface alu_seq_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             flag_c;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;
  logic             err;
  logic             busy;

  modport slave (
    input  in_valid, op, a, b, c_in, out_ready,
    output in_ready, out_valid, y, flag_c, flag_z, flag_n, flag_v, err, busy
  );

  modport master (
    output in_valid, op, a, b, c_in, out_ready,
    input  in_ready, out_valid, y, flag_c, flag_z, flag_n, flag_v, err, busy
  );
endinterface

// File: rtl/alu_seq_pipe.sv
// One-deep registered ALU stage with valid/ready on both sides, C/Z/N/V flags,
// illegal-op error and a serial (1 bit/cycle) or barrel shifter.
module alu_seq_pipe #(
  parameter int WIDTH        = 8,
  parameter bit SHIFT_SERIAL = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  alu_seq_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_INC  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_DEC  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_SAR  = 4'd10;
  localparam logic [3:0] OP_PASS = 4'd11;

  typedef enum logic {IDLE, SHIFT} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             c;
    logic             z;
    logic             n;
    logic             v;
    logic             err;
  } res_t;

  state_t           state, state_nx;
  res_t             res_q, res_nx, res_imm, res_ser;
  logic             out_valid_q;
  logic [WIDTH-1:0] work, step_work;
  logic             step_c;
  logic [SHW-1:0]   cnt;
  logic [3:0]       sh_op;
  logic [SHW-1:0]   n_in;
  logic             acc, is_shift, serial_go, load, wr;

  // Single-cycle result for every opcode; the barrel path also covers n=0 shifts.
  function automatic res_t alu_imm(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input logic cin,
                                   input logic [SHW-1:0] n);
    res_t           r;
    logic [WIDTH-1:0] bb;
    logic           ci;
    logic           arith;
    logic [WIDTH:0] s;
    logic [WIDTH:0] t;
    r     = '0;
    bb    = '0;
    ci    = cin;
    arith = 1'b0;
    t     = '0;
    case (op)
      OP_INC:  arith = 1'b1;
      OP_ADD:  begin arith = 1'b1; bb = b;  end
      OP_SUB:  begin arith = 1'b1; bb = ~b; end
      OP_DEC:  begin arith = 1'b1; bb = '1; ci = 1'b0; end
      OP_AND:  r.y = a & b;
      OP_OR:   r.y = a | b;
      OP_XOR:  r.y = a ^ b;
      OP_NOT:  r.y = ~a;
      // Extra guard bit catches the last bit shifted out as the carry.
      OP_SHL:  begin t = {1'b0, a} << n; r.y = t[WIDTH-1:0]; r.c = t[WIDTH]; end
      OP_SHR:  begin t = {a, 1'b0} >> n; r.y = t[WIDTH:1];   r.c = t[0];     end
      OP_SAR:  begin t = $signed({a, 1'b0}) >>> n; r.y = t[WIDTH:1]; r.c = t[0]; end
      OP_PASS: r.y = b;
      default: r.err = 1'b1;
    endcase
    s = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};
    if (arith) begin
      r.y = s[WIDTH-1:0];
      r.c = s[WIDTH];
      r.v = (a[WIDTH-1] == bb[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    end
    r.z = (r.y == '0);
    r.n = r.y[WIDTH-1];
    return r;
  endfunction

  assign n_in      = bus.b[SHW-1:0];
  assign is_shift  = (bus.op == OP_SHL) || (bus.op == OP_SHR) || (bus.op == OP_SAR);
  assign acc       = bus.in_valid && bus.in_ready;
  assign serial_go = SHIFT_SERIAL && is_shift && (n_in != '0);
  assign res_imm   = alu_imm(bus.op, bus.a, bus.b, bus.c_in, n_in);

  // One serial step; the final step's output is the result, so no carry register is needed.
  always_comb begin
    step_work = work >> 1;
    step_c    = work[0];
    case (sh_op)
      OP_SHL:  begin step_work = work << 1; step_c = work[WIDTH-1]; end
      OP_SAR:  step_work = {work[WIDTH-1], work[WIDTH-1:1]};
      default: ;
    endcase
    res_ser   = '0;
    res_ser.y = step_work;
    res_ser.c = step_c;
    res_ser.z = (step_work == '0);
    res_ser.n = step_work[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    wr       = 1'b0;
    res_nx   = res_imm;
    case (state)
      IDLE: begin
        if (acc) begin
          if (serial_go) begin
            load     = 1'b1;
            state_nx = SHIFT;
          end else begin
            wr = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (cnt == SHW'(1)) begin
          wr       = 1'b1;
          res_nx   = res_ser;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q       <= '0;
      out_valid_q <= 1'b0;
      work        <= '0;
      cnt         <= '0;
      sh_op       <= '0;
    end else begin
      if (load) begin
        work  <= bus.a;
        cnt   <= n_in;
        sh_op <= bus.op;
      end else if (state == SHIFT) begin
        work <= step_work;
        cnt  <= cnt - SHW'(1);
      end
      // A new result overwrites a draining one in the same edge, keeping 1 op/cycle.
      if (wr) begin
        res_q       <= res_nx;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = rst_n && (state == IDLE) && (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state == SHIFT);
  assign bus.y         = res_q.y;
  assign bus.flag_c    = res_q.c;
  assign bus.flag_z    = res_q.z;
  assign bus.flag_n    = res_q.n;
  assign bus.flag_v    = res_q.v;
  assign bus.err       = res_q.err;
endmodule

// File: tb/tb_alu_seq_pipe.sv
// Bench for alu_seq_pipe: serial and barrel instances, scoreboard queues fed at accept time.
module tb_alu_seq_pipe;
  localparam int W = 8;
  localparam logic [3:0] INC = 4'd0, ADD = 4'd1, SUB = 4'd2, DEC = 4'd3, AND_ = 4'd4,
                         OR_ = 4'd5, XOR_ = 4'd6, NOT_ = 4'd7, SHL = 4'd8, SHR = 4'd9,
                         SAR = 4'd10, PASS = 4'd11, ILL = 4'd12;

  typedef struct packed {
    logic [7:0] y;
    logic c, z, n, v, err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t qs[$];
  exp_t qb[$];
  exp_t es, eb, h;

  always #5 clk = ~clk;

  alu_seq_pipe_if #(.WIDTH(W)) si ();
  alu_seq_pipe_if #(.WIDTH(W)) bi ();

  alu_seq_pipe #(.WIDTH(W), .SHIFT_SERIAL(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(si));
  alu_seq_pipe #(.WIDTH(W), .SHIFT_SERIAL(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bi));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: integer arithmetic for overflow, bit-at-a-time loops for shifts.
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic cin);
    exp_t e;
    logic [8:0] u;
    logic [7:0] w, nb;
    int r, n;
    e  = '0;
    n  = int'(b[2:0]);
    w  = a;
    nb = ~b;
    case (op)
      INC: begin u = 9'(a) + 9'(cin); r = int'($signed(a)) + int'(cin);
                 e.y = u[7:0]; e.c = u[8]; e.v = (r > 127) || (r < -128); end
      ADD: begin u = 9'(a) + 9'(b) + 9'(cin); r = int'($signed(a)) + int'($signed(b)) + int'(cin);
                 e.y = u[7:0]; e.c = u[8]; e.v = (r > 127) || (r < -128); end
      SUB: begin u = 9'(a) + 9'(nb) + 9'(cin); r = int'($signed(a)) + int'($signed(nb)) + int'(cin);
                 e.y = u[7:0]; e.c = u[8]; e.v = (r > 127) || (r < -128); end
      DEC: begin u = 9'(a) + 9'h0FF; r = int'($signed(a)) - 1;
                 e.y = u[7:0]; e.c = u[8]; e.v = (r > 127) || (r < -128); end
      AND_: e.y = a & b;
      OR_:  e.y = a | b;
      XOR_: e.y = a ^ b;
      NOT_: e.y = ~a;
      SHL: begin for (int i = 0; i < n; i++) begin e.c = w[7]; w = {w[6:0], 1'b0}; end e.y = w; end
      SHR: begin for (int i = 0; i < n; i++) begin e.c = w[0]; w = {1'b0, w[7:1]}; end e.y = w; end
      SAR: begin for (int i = 0; i < n; i++) begin e.c = w[0]; w = {w[7], w[7:1]}; end e.y = w; end
      PASS: e.y = b;
      default: e.err = 1'b1;
    endcase
    e.z = (e.y == 8'h00);
    e.n = e.y[7];
    return e;
  endfunction

  // Drive one op, wait for acceptance (bounded), push the expectation, then scramble inputs.
  task automatic send(input bit bar, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic cin);
    bit got = 1'b0;
    if (bar) begin bi.in_valid = 1'b1; bi.op = op; bi.a = a; bi.b = b; bi.c_in = cin; end
    else     begin si.in_valid = 1'b1; si.op = op; si.a = a; si.b = b; si.c_in = cin; end
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = bar ? bi.in_ready : si.in_ready;
    end
    if (!got) chk("accept_timeout", 32'(got), 32'd1);
    else if (bar) qb.push_back(model(op, a, b, cin));
    else          qs.push_back(model(op, a, b, cin));
    @(posedge clk);
    #1;
    if (bar) begin bi.in_valid = 1'b0; bi.op = 4'($urandom); bi.a = 8'($urandom); bi.b = 8'($urandom); end
    else     begin si.in_valid = 1'b0; si.op = 4'($urandom); si.a = 8'($urandom); si.b = 8'($urandom); end
  endtask

  // Handshake seen at the negedge is the transfer taken at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && si.out_valid && si.out_ready) begin
      if (qs.size() == 0) chk("s_unexpected_out", 32'(qs.size()), 32'd1);
      else begin
        es = qs.pop_front();
        chk("s_y", si.y, es.y);
        chk("s_flags", {si.flag_c, si.flag_z, si.flag_n, si.flag_v, si.err}, {es.c, es.z, es.n, es.v, es.err});
      end
    end
    if (rst_n && bi.out_valid && bi.out_ready) begin
      if (qb.size() == 0) chk("b_unexpected_out", 32'(qb.size()), 32'd1);
      else begin
        eb = qb.pop_front();
        chk("b_y", bi.y, eb.y);
        chk("b_flags", {bi.flag_c, bi.flag_z, bi.flag_n, bi.flag_v, bi.err}, {eb.c, eb.z, eb.n, eb.v, eb.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    si.in_valid = 1'b0; si.op = '0; si.a = '0; si.b = '0; si.c_in = 1'b0; si.out_ready = 1'b1;
    bi.in_valid = 1'b0; bi.op = '0; bi.a = '0; bi.b = '0; bi.c_in = 1'b0; bi.out_ready = 1'b1;
    #2;
    chk("rst_y", si.y, 0);
    chk("rst_flags", {si.flag_c, si.flag_z, si.flag_n, si.flag_v, si.err}, 0);
    chk("rst_out_valid", si.out_valid, 0);
    chk("rst_busy", si.busy, 0);
    chk("rst_in_ready_s", si.in_ready, 0);
    chk("rst_in_ready_b", bi.in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", si.in_ready, 1);

    // Arithmetic / logic directed cases, latency 1, back-to-back.
    send(0, ADD, 8'hFF, 8'h01, 1'b0);
    chk("add_lat1", si.out_valid, 1);
    send(0, SUB, 8'h80, 8'h01, 1'b1);
    send(0, ADD, 8'h7F, 8'h01, 1'b0);
    send(0, INC, 8'hFF, 8'h00, 1'b1);
    send(0, DEC, 8'h00, 8'h00, 1'b1);
    send(0, DEC, 8'h80, 8'h00, 1'b0);
    send(0, AND_, 8'hF0, 8'h3C, 1'b0);
    send(0, OR_, 8'hF0, 8'h0C, 1'b1);
    send(0, XOR_, 8'hAA, 8'hAA, 1'b0);
    send(0, NOT_, 8'h5A, 8'h00, 1'b1);
    send(0, PASS, 8'h00, 8'h99, 1'b1);
    send(0, ILL, 8'h12, 8'h34, 1'b1);
    chk("ill_err", si.err, 1);

    // Serial shift: busy and in_ready low for n cycles, result on the n-th edge.
    send(0, SHL, 8'h81, 8'h03, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("shl_busy", si.busy, 1);
      chk("shl_in_ready", si.in_ready, 0);
      chk("shl_no_valid", si.out_valid, 0);
      @(posedge clk); #1;
    end
    chk("shl_done_valid", si.out_valid, 1);
    chk("shl_done_busy", si.busy, 0);
    send(0, SAR, 8'h90, 8'h02, 1'b0);
    send(0, SHR, 8'h81, 8'h07, 1'b0);
    send(0, SHL, 8'h5A, 8'h00, 1'b0);
    chk("shl_n0_lat1", si.out_valid, 1);

    // Barrel instance.
    send(1, SHR, 8'hF0, 8'h04, 1'b0);
    chk("b_shr_lat1", bi.out_valid, 1);
    send(1, SHL, 8'hA5, 8'h00, 1'b1);
    send(1, SAR, 8'h90, 8'h02, 1'b0);
    send(1, SHL, 8'h81, 8'h07, 1'b0);

    // Output hold under backpressure, then drain + accept in the same edge.
    repeat (2) @(posedge clk); #1;
    si.out_ready = 1'b0;
    h = model(ADD, 8'h7F, 8'h01, 1'b0);
    send(0, ADD, 8'h7F, 8'h01, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", si.out_valid, 1);
      chk("hold_in_ready", si.in_ready, 0);
      chk("hold_y", si.y, h.y);
      chk("hold_flags", {si.flag_c, si.flag_z, si.flag_n, si.flag_v, si.err}, {h.c, h.z, h.n, h.v, h.err});
      @(posedge clk); #1;
    end
    si.out_ready = 1'b1;
    send(0, XOR_, 8'h0F, 8'hFF, 1'b0);
    chk("b2b_valid", si.out_valid, 1);
    send(0, SUB, 8'h10, 8'h20, 1'b1);
    chk("b2b_valid2", si.out_valid, 1);

    // Random mix on both instances.
    for (int i = 0; i < 25; i++) begin
      send(0, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'($urandom));
      send(1, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'($urandom));
    end
    repeat (3) @(posedge clk); #1;

    // Reset in the middle of a long serial shift aborts it.
    send(0, SHL, 8'h3C, 8'h07, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_y", si.y, 0);
    chk("abort_flags", {si.flag_c, si.flag_z, si.flag_n, si.flag_v, si.err}, 0);
    chk("abort_valid", si.out_valid, 0);
    chk("abort_busy", si.busy, 0);
    chk("abort_in_ready", si.in_ready, 0);
    qs.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", si.out_valid, 0);
    end
    send(0, ADD, 8'h01, 8'h02, 1'b0);
    repeat (5) @(posedge clk); #1;
    chk("qs_drained", qs.size(), 0);
    chk("qb_drained", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
